// File: rtl/regbank_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_mp
//  Description : Multi-port CPU register bank with two writeback ports,
//                registered forwarding reads and a per-register busy
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    input  logic [NRD-1:0]           rd_clear,
    input  logic [NRD-1:0]           rd_hold,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     res_en,
    input  logic [ADDR_W-1:0]        res_addr
);

    localparam int C_NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_regs [C_NREGS];
    logic [C_NREGS-1:0] r_busy;
    logic [C_NREGS-1:0] w_busy_nxt;
    logic               w_wr0_ok;
    logic               w_wr1_ok;
    logic               w_res_ok;

    // Port 1 is suppressed when port 0 targets the same register.
    assign w_wr0_ok = wr0_en && (wr0_addr != '0);
    assign w_wr1_ok = wr1_en && (wr1_addr != '0) && !(w_wr0_ok && (wr1_addr == wr0_addr));
    assign w_res_ok = res_en && (res_addr != '0);

    // Reserve is applied last so a new producer owns a register written this cycle.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0_ok) w_busy_nxt[wr0_addr] = 1'b0;
        if (w_wr1_ok) w_busy_nxt[wr1_addr] = 1'b0;
        if (w_res_ok) w_busy_nxt[res_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < C_NREGS; j++) r_regs[j] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
            if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] r_data;
        logic              r_bsy;

        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
                r_bsy  <= 1'b0;
            end else if (rd_clear[i]) begin
                r_data <= '0;
                r_bsy  <= 1'b0;
            end else if (!rd_hold[i]) begin
                if (w_addr == '0) begin
                    r_data <= '0;
                    r_bsy  <= 1'b0;
                end else begin
                    if (w_wr0_ok && (w_addr == wr0_addr))
                        r_data <= wr0_data;
                    else if (w_wr1_ok && (w_addr == wr1_addr))
                        r_data <= wr1_data;
                    else
                        r_data <= r_regs[w_addr];
                    r_bsy <= w_busy_nxt[w_addr];
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = r_data;
        assign rd_busy[i]                  = r_bsy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regbank_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_mp
//  Description : Self-checking bench for regbank_mp: directed vector table,
//                reset/parametrisation sequences and randomized traffic
//                against a behavioural register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rd_addr;
    logic [2:0]  rd_clear, rd_hold;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        wr0_en, wr1_en, res_en;
    logic [3:0]  wr0_addr, wr1_addr, res_addr;
    logic [31:0] wr0_data, wr1_data;

    logic [19:0] p_rd_addr;
    logic [63:0] p_rd_data;
    logic [3:0]  p_rd_busy;
    logic        p_wr0_en;
    logic [4:0]  p_wr0_addr;
    logic [15:0] p_wr0_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regbank_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_hold(rd_hold), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .res_en(res_en), .res_addr(res_addr)
    );

    regbank_mp #(.DATA_W(16), .ADDR_W(5), .NRD(4)) dut_p (
        .clk(clk), .reset(reset), .rd_addr(p_rd_addr), .rd_clear(4'b0),
        .rd_hold(4'b0), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
        .wr0_en(p_wr0_en), .wr0_addr(p_wr0_addr), .wr0_data(p_wr0_data),
        .wr1_en(1'b0), .wr1_addr(5'd0), .wr1_data(16'h0),
        .res_en(1'b0), .res_addr(5'd0)
    );

    // Write trace of accepted writes
    always @(posedge clk) begin
        if (!reset) begin
            if (wr0_en && wr0_addr != 4'd0)
                $display("[TRACE] t=%0t port0 r%0d <= %h", $time, wr0_addr, wr0_data);
            if (wr1_en && wr1_addr != 4'd0 && !(wr0_en && wr0_addr == wr1_addr))
                $display("[TRACE] t=%0t port1 r%0d <= %h", $time, wr1_addr, wr1_data);
        end
    end

    // Behavioural model: architectural state after each edge
    logic [31:0] m_regs [16];
    logic        m_busy [16];
    logic [31:0] m_rd   [3];
    logic        m_rb   [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 16; j++) begin
            m_regs[j] = '0;
            m_busy[j] = 1'b0;
        end
        for (int p = 0; p < 3; p++) begin
            m_rd[p] = '0;
            m_rb[p] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        rd_addr = '0; rd_clear = '0; rd_hold = '0;
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        res_en = 0; res_addr = 0;
    endtask

    // Inputs are already driven; compute post-edge state, clock, compare all ports.
    task automatic cycle();
        logic [31:0] nr [16];
        logic        nb [16];
        logic [3:0]  a;
        nr = m_regs;
        nb = m_busy;
        if (wr1_en && wr1_addr != 0) begin nr[wr1_addr] = wr1_data; nb[wr1_addr] = 1'b0; end
        if (wr0_en && wr0_addr != 0) begin nr[wr0_addr] = wr0_data; nb[wr0_addr] = 1'b0; end
        if (res_en && res_addr != 0) nb[res_addr] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            a = rd_addr[p*4 +: 4];
            if (rd_clear[p]) begin
                m_rd[p] = '0; m_rb[p] = 1'b0;
            end else if (!rd_hold[p]) begin
                m_rd[p] = nr[a]; m_rb[p] = nb[a];
            end
        end
        @(posedge clk);
        #1;
        m_regs = nr;
        m_busy = nb;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("model_data p%0d", p), rd_data[p*32 +: 32], m_rd[p]);
            check($sformatf("model_busy p%0d", p), {31'b0, rd_busy[p]}, {31'b0, m_rb[p]});
        end
    endtask

    typedef struct {
        logic        w0e; logic [3:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [3:0] w1a; logic [31:0] w1d;
        logic        re;  logic [3:0] ra;
        logic [11:0] rda;
        logic [2:0]  clr; logic [2:0] hld;
        int          port;
        logic [31:0] ed;  logic eb;
    } vec_t;

    function automatic vec_t mk(
        input logic w0e, input logic [3:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [3:0] w1a, input logic [31:0] w1d,
        input logic re, input logic [3:0] ra,
        input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
        input logic [2:0] clr, input logic [2:0] hld,
        input int port, input logic [31:0] ed, input logic eb);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.re = re; v.ra = ra; v.rda = {a2, a1, a0};
        v.clr = clr; v.hld = hld; v.port = port; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        vecs.push_back(mk(1,3,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 0,0, 0, 32'h0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,3,0, 0,0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0, 0,0, 0,0,0, 0,0, 0, 32'h0, 0));
        vecs.push_back(mk(1,7,32'h11, 1,7,32'h22, 0,0, 7,0,0, 0,0, 0, 32'h11, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,0,0, 0,0, 0, 32'h11, 0));
        vecs.push_back(mk(0,0,0, 1,8,32'h33, 0,0, 0,8,0, 0,0, 1, 32'h33, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3, 0,0, 2, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1,3,32'h55, 0,0,0, 0,0, 0,0,3, 0,3'b100, 2, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3, 0,0, 2, 32'h55, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3, 3'b100,3'b100, 2, 32'h0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,4, 4,0,0, 0,0, 0, 32'h0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 4,0,0, 0,0, 0, 32'h0, 1));
        vecs.push_back(mk(0,0,0, 1,4,32'h99, 0,0, 4,0,0, 0,0, 0, 32'h99, 0));
        vecs.push_back(mk(1,4,32'hAA, 0,0,0, 1,4, 4,0,0, 0,0, 0, 32'hAA, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0, 0,0, 0, 32'h0, 0));
        vecs.push_back(mk(1,9,32'h1, 1,9,32'h2, 1,9, 0,0,9, 0,0, 2, 32'h1, 1));

        idle_inputs();
        p_rd_addr = '0; p_wr0_en = 0; p_wr0_addr = 0; p_wr0_data = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", rd_data[31:0], 32'h0);
        check("reset_busy", {29'b0, rd_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        foreach (vecs[k]) begin
            @(negedge clk);
            wr0_en = vecs[k].w0e; wr0_addr = vecs[k].w0a; wr0_data = vecs[k].w0d;
            wr1_en = vecs[k].w1e; wr1_addr = vecs[k].w1a; wr1_data = vecs[k].w1d;
            res_en = vecs[k].re;  res_addr = vecs[k].ra;
            rd_addr = vecs[k].rda; rd_clear = vecs[k].clr; rd_hold = vecs[k].hld;
            cycle();
            check($sformatf("vec%0d_data", k), rd_data[vecs[k].port*32 +: 32], vecs[k].ed);
            check($sformatf("vec%0d_busy", k), {31'b0, rd_busy[vecs[k].port]}, {31'b0, vecs[k].eb});
        end

        // Mid-run reset discards contents and in-flight work
        @(negedge clk); idle_inputs();
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h12345678;
        cycle();
        @(negedge clk); idle_inputs();
        rd_addr = {4'd5, 4'd5, 4'd5};
        cycle();
        check("pre_reset_r5", rd_data[63:32], 32'h12345678);
        @(negedge clk);
        wr0_en = 1; wr0_addr = 6; wr0_data = 32'hCAFE0006;
        res_en = 1; res_addr = 6;
        reset = 1'b1;
        #1;
        check("async_reset_data", rd_data[95:64], 32'h0);
        check("async_reset_busy", {29'b0, rd_busy}, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        rd_addr = {4'd5, 4'd5, 4'd5};
        cycle();
        for (int p = 0; p < 3; p++)
            check($sformatf("post_reset_r5_p%0d", p), rd_data[p*32 +: 32], 32'h0);
        @(negedge clk); idle_inputs();
        rd_addr = {4'd6, 4'd6, 4'd6};
        cycle();
        check("post_reset_r6", rd_data[31:0], 32'h0);
        check("post_reset_r6_busy", {31'b0, rd_busy[0]}, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 4'($urandom); wr0_data = $urandom;
            wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 4'($urandom); wr1_data = $urandom;
            if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
            res_en = ($urandom_range(0, 2) == 0); res_addr = 4'($urandom);
            rd_addr = 12'($urandom);
            rd_clear = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b0;
            rd_hold  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            cycle();
        end

        // Wider-address, narrower-data configuration
        @(negedge clk); idle_inputs();
        p_wr0_en = 1; p_wr0_addr = 5'd31; p_wr0_data = 16'hBEEF;
        @(negedge clk);
        p_wr0_en = 0;
        p_rd_addr = {5'd31, 5'd31, 5'd31, 5'd31};
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("param_r31_p%0d", p), {16'b0, p_rd_data[p*16 +: 16]}, 32'h0000BEEF);
        @(negedge clk);
        p_rd_addr = '0;
        @(posedge clk); #1;
        check("param_r0", {16'b0, p_rd_data[15:0]}, 32'h0);
        check("param_busy", {28'b0, p_rd_busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
